// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave keypad/timer controller.
// Used by the BCD MM:SS counter and the top-level sequencer.
package microwave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_COOKING,
        ST_PAUSED,
        ST_DONE
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX_DIGIT    = 4'd9;
    localparam bcd_t BCD_MAX_SEC_TENS = 4'd5;

endpackage

// File: rtl/bcd_mmss_counter.sv
// Four-digit BCD MM:SS register: shift-in of keyed digits, clear, and a
// borrowing decrement that never goes below 00:00.
module bcd_mmss_counter
    import microwave_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic shift_en,
    input  bcd_t shift_digit,
    input  logic dec,
    output bcd_t min_tens,
    output bcd_t min_ones,
    output bcd_t sec_tens,
    output bcd_t sec_ones,
    output logic is_zero,
    output logic is_one
);

    bcd_t mt_q, mo_q, st_q, so_q;
    bcd_t mt_d, mo_d, st_d, so_d;

    assign is_zero = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd0);
    assign is_one  = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd1);

    always_comb begin
        mt_d = mt_q;
        mo_d = mo_q;
        st_d = st_q;
        so_d = so_q;
        if (clear) begin
            mt_d = 4'd0;
            mo_d = 4'd0;
            st_d = 4'd0;
            so_d = 4'd0;
        end else if (shift_en) begin
            mt_d = mo_q;
            mo_d = st_q;
            st_d = so_q;
            so_d = shift_digit;
        end else if (dec && !is_zero) begin
            // Seconds tens above 5 (e.g. 75) just count down; a borrow from 0 reloads 5.
            if (so_q != 4'd0) begin
                so_d = so_q - 4'd1;
            end else begin
                so_d = BCD_MAX_DIGIT;
                if (st_q != 4'd0) begin
                    st_d = st_q - 4'd1;
                end else begin
                    st_d = BCD_MAX_SEC_TENS;
                    if (mo_q != 4'd0) begin
                        mo_d = mo_q - 4'd1;
                    end else begin
                        mo_d = BCD_MAX_DIGIT;
                        mt_d = mt_q - 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mt_q <= 4'd0;
            mo_q <= 4'd0;
            st_q <= 4'd0;
            so_q <= 4'd0;
        end else begin
            mt_q <= mt_d;
            mo_q <= mo_d;
            st_q <= st_d;
            so_q <= so_d;
        end
    end

    assign min_tens = mt_q;
    assign min_ones = mo_q;
    assign sec_tens = st_q;
    assign sec_ones = so_q;

endmodule

// File: rtl/microwave_controller.sv
// Microwave sequencer: key capture, cook countdown, magnetron control.
// Optional done beep enabled by defining MICROWAVE_DONE_BEEP_EN.
module microwave_controller
    import microwave_pkg::*;
#(
    parameter int CLKS_PER_SEC = 10,
    parameter int BEEP_CLKS    = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] digit,
    input  logic       loadn,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    output logic       enablen,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       magnetron_on,
    output logic       done,
    output logic       beep
);

    localparam int TICK_W = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_SEC - 1);

    state_e            state_q, state_d;
    logic              loadn_prev_q, loadn_prev_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              enablen_q, enablen_d;
    logic              mag_q, mag_d;
    logic              done_q, done_d;

    logic key_edge, key_ok, tick;
    logic cnt_clear, cnt_shift, cnt_dec;
    logic is_zero, is_one;

    assign key_edge = loadn_prev_q && !loadn;
    assign key_ok   = key_edge && (digit <= BCD_MAX_DIGIT);
    assign tick     = (tick_cnt_q == TICK_LAST);

    always_comb begin
        state_d      = state_q;
        loadn_prev_d = loadn;
        cnt_clear    = 1'b0;
        cnt_shift    = 1'b0;
        cnt_dec      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (key_ok) begin
                    cnt_shift = 1'b1;
                    state_d   = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (!stopn) begin
                    cnt_clear = 1'b1;
                    state_d   = ST_IDLE;
                end else if (!startn && door_closed && !is_zero) begin
                    state_d = ST_COOKING;
                end else if (key_ok) begin
                    cnt_shift = 1'b1;
                end
            end
            ST_COOKING: begin
                // Door/stop beats a coincident tick: time freezes.
                if (!stopn || !door_closed) begin
                    state_d = ST_PAUSED;
                end else if (tick) begin
                    cnt_dec = 1'b1;
                    if (is_one) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_PAUSED: begin
                if (!stopn) begin
                    cnt_clear = 1'b1;
                    state_d   = ST_IDLE;
                end else if (!startn && door_closed) begin
                    state_d = ST_COOKING;
                end
            end
            ST_DONE: begin
                if (!stopn || !door_closed || key_edge) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Divider is held at zero outside COOKING, so every entry starts a full second.
    always_comb begin
        tick_cnt_d = '0;
        if (state_q == ST_COOKING && !tick) begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
    end

    always_comb begin
        enablen_d = (state_d == ST_COOKING) || (state_d == ST_PAUSED) || (state_d == ST_DONE);
        mag_d     = (state_d == ST_COOKING);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            loadn_prev_q <= 1'b1;
            tick_cnt_q   <= '0;
            enablen_q    <= 1'b0;
            mag_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            loadn_prev_q <= loadn_prev_d;
            tick_cnt_q   <= tick_cnt_d;
            enablen_q    <= enablen_d;
            mag_q        <= mag_d;
            done_q       <= done_d;
        end
    end

    bcd_mmss_counter u_time (
        .clk        (clk),
        .rst_n      (resetn),
        .clear      (cnt_clear),
        .shift_en   (cnt_shift),
        .shift_digit(digit),
        .dec        (cnt_dec),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .is_zero    (is_zero),
        .is_one     (is_one)
    );

`ifdef MICROWAVE_DONE_BEEP_EN
    localparam int BEEP_W = $clog2(BEEP_CLKS + 1);

    logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;

    // Loaded on entry to DONE, counts down while DONE is held; leaving DONE cuts it short.
    always_comb begin
        beep_cnt_d = '0;
        if (state_d == ST_DONE) begin
            if (state_q != ST_DONE) begin
                beep_cnt_d = BEEP_W'(BEEP_CLKS);
            end else if (beep_cnt_q != '0) begin
                beep_cnt_d = beep_cnt_q - BEEP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            beep_cnt_q <= '0;
        end else begin
            beep_cnt_q <= beep_cnt_d;
        end
    end

    assign beep = (beep_cnt_q != '0);
`else
    assign beep = 1'b0;
`endif

    assign enablen      = enablen_q;
    assign magnetron_on = mag_q;
    assign done         = done_q;

endmodule
